// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, loader command classes and FSM states
package riscv_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [2:0] {
        CLS_LW    = 3'd0,
        CLS_SW    = 3'd1,
        CLS_RTYPE = 3'd2,
        CLS_BEQ   = 3'd3,
        CLS_ITYPE = 3'd4,
        CLS_JAL   = 3'd5,
        CLS_JALR  = 3'd6
    } cmd_class_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FULL  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - command stream, IMEM write port and status of the loader
interface instr_mem_loader_if #(
    parameter int AW = 10
);
    logic          start;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_last;
    logic [2:0]    cmd_class;
    logic [2:0]    cmd_funct3;
    logic          cmd_funct7b5;
    logic [4:0]    cmd_rd;
    logic [4:0]    cmd_rs1;
    logic [4:0]    cmd_rs2;
    logic [31:0]   cmd_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          enc_err;

    modport master (
        output start, cmd_valid, cmd_last, cmd_class, cmd_funct3, cmd_funct7b5,
               cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready, imem_we, imem_addr, imem_wdata, busy, done, overflow, enc_err
    );

    modport slave (
        input  start, cmd_valid, cmd_last, cmd_class, cmd_funct3, cmd_funct7b5,
               cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready, imem_we, imem_addr, imem_wdata, busy, done, overflow, enc_err
    );
endinterface

// File: rtl/instr_field_packer.sv
// rtl/instr_field_packer.sv - combinational field-to-RV32I word packer
// INSTR_LOADER_CHECK_EN adds immediate range checking and rejects unknown classes.
module instr_field_packer
    import riscv_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        word_ok
);
    logic class_ok;

    always_comb begin
        word     = NOP;
        class_ok = 1'b1;
        case (cls)
            CLS_LW:    word = {imm[11:0], rs1, 3'b010, rd, OP_LW};
            CLS_SW:    word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW};
            CLS_RTYPE: word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_R};
            CLS_BEQ:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
            CLS_ITYPE: begin
                word = {imm[11:0], rs1, funct3, rd, OP_I};
                // srli/srai share funct3 101; bit 30 selects the arithmetic form
                if (funct3 == 3'b101) word[30] = funct7b5;
            end
            CLS_JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            CLS_JALR:  word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            default:   class_ok = 1'b0;
        endcase
    end

`ifdef INSTR_LOADER_CHECK_EN
    logic signed [31:0] simm;
    logic               range_ok;

    assign simm = imm;

    always_comb begin
        range_ok = 1'b1;
        case (cls)
            CLS_LW, CLS_SW, CLS_ITYPE, CLS_JALR:
                range_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            CLS_BEQ:
                range_ok = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
            CLS_JAL:
                range_ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
            default: range_ok = 1'b1;
        endcase
    end

    assign word_ok = class_ok && range_ok;
`else
    logic unused_fields;

    // unknown classes fall through as NOP and oversized immediates are truncated
    assign unused_fields = ^{class_ok, imm[31:21]};
    assign word_ok       = 1'b1;
`endif

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - packs instruction commands and writes them sequentially into IMEM
// INSTR_LOADER_CHECK_EN enables immediate range checking and the sticky enc_err flag.
module instr_mem_loader
    import riscv_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DEPTH = 1024,
    parameter int BASE  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_mem_loader_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          overflow_q, overflow_d;
    logic          enc_err_q, enc_err_d;

    logic [31:0]   word;
    logic          word_ok;
    logic          accept;

    instr_field_packer u_packer (
        .cls      (bus.cmd_class),
        .funct3   (bus.cmd_funct3),
        .funct7b5 (bus.cmd_funct7b5),
        .rd       (bus.cmd_rd),
        .rs1      (bus.cmd_rs1),
        .rs2      (bus.cmd_rs2),
        .imm      (bus.cmd_imm),
        .word     (word),
        .word_ok  (word_ok)
    );

    assign accept = bus.cmd_valid && (state_q == ST_LOAD);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        waddr_d    = waddr_q;
        count_d    = count_q;
        wdata_d    = wdata_q;
        overflow_d = overflow_q;
        enc_err_d  = enc_err_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_LOAD;
                    addr_d     = AW'(BASE);
                    count_d    = '0;
                    overflow_d = 1'b0;
                    enc_err_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (count_q == CW'(DEPTH)) begin
                        // the overflowing command ends the session even without cmd_last
                        overflow_d = 1'b1;
                        state_d    = ST_FULL;
                    end else begin
                        if (word_ok) begin
                            we_d    = 1'b1;
                            waddr_d = addr_q;
                            wdata_d = word;
                            addr_d  = addr_q + 1'b1;
                            count_d = count_q + 1'b1;
                        end else begin
                            enc_err_d = 1'b1;
                        end
                        if (bus.cmd_last) state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN, ST_FULL: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= AW'(BASE);
            waddr_q    <= '0;
            count_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            enc_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            waddr_q    <= waddr_d;
            count_q    <= count_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            enc_err_q  <= enc_err_d;
        end
    end

    // gating with rst_n kills a write already registered when reset arrives
    assign bus.imem_we    = we_q && rst_n;
    assign bus.imem_addr  = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cmd_ready  = (state_q == ST_LOAD);
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overflow   = overflow_q;

`ifdef INSTR_LOADER_CHECK_EN
    assign bus.enc_err = enc_err_q;
`else
    logic unused_enc_err;

    assign unused_enc_err = enc_err_q;
    assign bus.enc_err    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - randomized self-checking bench with a behavioural loader model
module tb_instr_mem_loader;
    import riscv_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int BASE  = 14;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_mem_loader_if #(.AW(AW)) bus ();

    instr_mem_loader #(.AW(AW), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // spec-level encoder: returns {writable, word}
    function automatic logic [32:0] model_enc(input int cls, input int f3, input int f7,
                                              input int rd, input int rs1, input int rs2,
                                              input int imm);
        logic [31:0] w;
        bit          ok;
        int          iv;
        ok = 1'b1;
        case (cls)
            0: begin
                w  = ((imm & 4095) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 3;
                ok = (imm >= -2048) && (imm <= 2047);
            end
            1: begin
                w  = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                   | ((imm & 31) << 7) | 35;
                ok = (imm >= -2048) && (imm <= 2047);
            end
            2: w = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 51;
            3: begin
                w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 15) << 8)
                   | (((imm >> 11) & 1) << 7) | 99;
                ok = (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
            end
            4: begin
                iv = imm & 4095;
                if (f3 == 5) iv = (iv & ~1024) | (f7 << 10);
                w  = (iv << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 19;
                ok = (imm >= -2048) && (imm <= 2047);
            end
            5: begin
                w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | (rd << 7) | 111;
                ok = (imm >= -1048576) && (imm <= 1048574) && ((imm & 1) == 0);
            end
            6: begin
                w  = ((imm & 4095) << 20) | (rs1 << 15) | (rd << 7) | 103;
                ok = (imm >= -2048) && (imm <= 2047);
            end
            default: begin
                w  = 32'h00000013;
                ok = 1'b0;
            end
        endcase
`ifndef INSTR_LOADER_CHECK_EN
        ok = 1'b1;
`endif
        return {ok, w};
    endfunction

    // model state
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_data;
    logic [AW-1:0] m_addr;
    logic [1:0]    done_pipe;
    logic          m_busy, m_ready, m_ov, m_enc;
    int            m_count;
    logic          nb, nr, endn, wen;
    logic [32:0]   enc_r;
    logic [AW+31:0] wlog[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            check("imem_we_in_reset", 32'(bus.imem_we), 32'd0);
            exp_we = 1'b0; exp_addr = '0; exp_data = '0; m_addr = AW'(BASE);
            done_pipe = 2'b00; m_busy = 1'b0; m_ready = 1'b0; m_ov = 1'b0; m_enc = 1'b0;
            m_count = 0;
        end else begin
            if (bus.imem_we) wlog.push_back({bus.imem_addr, bus.imem_wdata});
            check("imem_we", 32'(bus.imem_we), 32'(exp_we));
            check("imem_addr", 32'(bus.imem_addr), 32'(exp_addr));
            check("imem_wdata", bus.imem_wdata, exp_data);
            check("done", 32'(bus.done), 32'(done_pipe[1]));
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("cmd_ready", 32'(bus.cmd_ready), 32'(m_ready));
            check("overflow", 32'(bus.overflow), 32'(m_ov));
            check("enc_err", 32'(bus.enc_err), 32'(m_enc));

            nb = m_busy; nr = m_ready; endn = 1'b0; wen = 1'b0;
            if (done_pipe[1]) nb = 1'b0;
            if (bus.start && !m_busy) begin
                nb = 1'b1; nr = 1'b1; m_addr = AW'(BASE); m_count = 0; m_ov = 1'b0; m_enc = 1'b0;
            end
            if (m_ready && bus.cmd_valid) begin
                if (m_count == DEPTH) begin
                    m_ov = 1'b1; endn = 1'b1; nr = 1'b0;
                end else begin
                    enc_r = model_enc(int'(bus.cmd_class), int'(bus.cmd_funct3),
                                      int'(bus.cmd_funct7b5), int'(bus.cmd_rd),
                                      int'(bus.cmd_rs1), int'(bus.cmd_rs2), int'(bus.cmd_imm));
                    if (enc_r[32]) begin
                        wen = 1'b1; exp_addr = m_addr; exp_data = enc_r[31:0];
                        m_addr = m_addr + 1'b1; m_count++;
                    end else begin
                        m_enc = 1'b1;
                    end
                    if (bus.cmd_last) begin
                        endn = 1'b1; nr = 1'b0;
                    end
                end
            end
            exp_we = wen; done_pipe = {done_pipe[0], endn}; m_busy = nb; m_ready = nr;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_start();
        wait_idle();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic send(input int cls, input int f3, input int f7, input int rd, input int rs1,
                        input int rs2, input int imm, input bit last, input bit st);
        int n = 0;
        bus.cmd_class = 3'(cls); bus.cmd_funct3 = 3'(f3); bus.cmd_funct7b5 = f7[0];
        bus.cmd_rd = 5'(rd); bus.cmd_rs1 = 5'(rs1); bus.cmd_rs2 = 5'(rs2);
        bus.cmd_imm = imm; bus.cmd_last = last; bus.cmd_valid = 1'b1; bus.start = st;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) check("accept_timeout", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; bus.cmd_last = 1'b0; bus.start = 1'b0;
    endtask

    task automatic check_log(input string name, input int idx, input int addr, input logic [31:0] data);
        if (idx < wlog.size()) check(name, wlog[idx][31:0], data);
        else check({name, "_missing"}, 32'(wlog.size()), 32'(idx + 1));
        if (idx < wlog.size()) check({name, "_addr"}, 32'(wlog[idx][AW+31:32]), 32'(addr % (1 << AW)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, imm, mode, cls;
        bus.start = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_last = 1'b0; bus.cmd_class = '0;
        bus.cmd_funct3 = '0; bus.cmd_funct7b5 = 1'b0; bus.cmd_rd = '0; bus.cmd_rs1 = '0;
        bus.cmd_rs2 = '0; bus.cmd_imm = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // LW, RTYPE add, SW back-to-back; third address wraps past 2**AW
        wlog.delete();
        do_start();
        send(0, 0, 0, 5, 1, 0, 8, 1'b0, 1'b0);
        send(2, 0, 0, 3, 1, 2, 0, 1'b0, 1'b0);
        send(1, 0, 0, 0, 1, 2, 4, 1'b1, 1'b0);
        wait_idle();
        check_log("lw_word", 0, BASE, 32'h0080A283);
        check_log("add_word", 1, BASE + 1, 32'h002081B3);
        check_log("sw_word", 2, BASE + 2, 32'h0020A223);

        // BEQ then JAL with cmd_last; done two cycles after the final accept
        wlog.delete();
        do_start();
        send(3, 0, 0, 0, 1, 2, -4, 1'b0, 1'b0);
        send(5, 0, 0, 1, 0, 0, 8, 1'b1, 1'b0);
        @(negedge clk);
        check("jal_we_lit", 32'(bus.imem_we), 32'd1);
        check("jal_done_early", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("jal_done_lit", 32'(bus.done), 32'd1);
        @(negedge clk);
        check("jal_busy_after", 32'(bus.busy), 32'd0);
        check_log("beq_word", 0, BASE, 32'hFE208EE3);
        check_log("jal_word", 1, BASE + 1, 32'h008000EF);

        // odd JAL offset
        wlog.delete();
        do_start();
        send(5, 0, 0, 1, 0, 0, 3, 1'b0, 1'b0);
        send(0, 0, 0, 5, 1, 0, 8, 1'b1, 1'b0);
        wait_idle();
`ifdef INSTR_LOADER_CHECK_EN
        check("enc_err_lit", 32'(bus.enc_err), 32'd1);
        check("enc_log_size", 32'(wlog.size()), 32'd1);
        check_log("enc_next_word", 0, BASE, 32'h0080A283);
`else
        check("enc_err_lit", 32'(bus.enc_err), 32'd0);
        check_log("jal_trunc_word", 0, BASE, 32'h002000EF);
        check_log("enc_next_word", 1, BASE + 1, 32'h0080A283);
`endif

        // five commands into a four-word session
        wlog.delete();
        do_start();
        for (int i = 0; i < 5; i++) send(2, 0, 0, i + 1, i, i + 2, 0, 1'b0, 1'b0);
        check("ovf_ready_drop", 32'(bus.cmd_ready), 32'd0);
        wait_idle();
        check("ovf_writes", 32'(wlog.size()), 32'd4);
        check("ovf_flag_lit", 32'(bus.overflow), 32'd1);

        // reset right after an accept suppresses the pending write
        wlog.delete();
        do_start();
        send(0, 0, 0, 5, 1, 0, 8, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        check("rst_no_write", 32'(wlog.size()), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        do_start();
        send(2, 0, 1, 7, 3, 4, 0, 1'b1, 1'b0);
        wait_idle();
        check_log("rst_restart_word", 0, BASE, 32'h404181B3 | (32'(7) << 7) ^ (32'(3) << 7));

        // randomized sessions
        for (int s = 0; s < 60; s++) begin
            do_start();
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                mode = $urandom_range(0, 3);
                case (mode)
                    0: imm = int'($urandom_range(0, 4095)) - 2048;
                    1: imm = int'($urandom_range(0, 8191)) - 4096;
                    2: imm = int'($urandom_range(0, 2097151)) - 1048576;
                    default: imm = int'($urandom);
                endcase
                cls = $urandom_range(0, 7);
                send(cls, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31), imm, (i == n - 1),
                     ($urandom_range(0, 3) == 0) && (i != n - 1));
                if (!bus.cmd_ready) break;
            end
            wait_idle();
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
